// File: rtl/edit_mem_rd_arb.sv
// edit_mem_rd_arb: shares the single edit-memory read port between NUM_REQ
// egress read engines. Round-robin arbitration with packet lock, an in-order
// tag FIFO of outstanding reads, and steering of read data back to the
// requester that issued each read.
module edit_mem_rd_arb #(
    parameter int NUM_REQ       = 4,
    parameter int REQ_ID_NBITS  = 2,
    parameter int ADDR_NBITS    = 10,
    parameter int ID_NBITS      = 4,
    parameter int DATA_NBITS    = 32,
    parameter int TAG_DEPTH     = 8,
    parameter int TAG_CNT_NBITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_NBITS-1:0] req_raddr,
    input  logic [NUM_REQ*ID_NBITS-1:0]   req_port_id,
    input  logic [NUM_REQ-1:0]            req_eop,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic                          edit_mem_req,
    output logic [ADDR_NBITS-1:0]         edit_mem_raddr,
    output logic [ID_NBITS-1:0]           edit_mem_port_id,
    output logic                          edit_mem_eop,
    input  logic                          edit_mem_ack,
    input  logic [DATA_NBITS-1:0]         edit_mem_rdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_NBITS-1:0]         rsp_data,
    output logic [TAG_CNT_NBITS-1:0]      outstanding,
    output logic                          err_unexp_ack
);

    localparam int PTR_NBITS = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [REQ_ID_NBITS-1:0] lock_id_q, lock_id_d;
    logic [REQ_ID_NBITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_NBITS-1:0] cand;
    logic [REQ_ID_NBITS-1:0] win_id;
    logic [REQ_ID_NBITS-1:0] rr_next;
    logic                    win_found;
    logic [NUM_REQ-1:0]      win_onehot;
    logic                    can_push;
    logic                    accept;
    logic                    pop;

    logic [REQ_ID_NBITS-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_NBITS-1:0]    wr_ptr_q, rd_ptr_q;
    logic [REQ_ID_NBITS-1:0] tag_head;

    // Winner selection: the locked requester, or the first valid one at or after rr_ptr.
    // The loop runs downward so the lowest offset from rr_ptr is the last to write.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        if (state_q == LOCKED) begin
            win_found = 1'b1;
            win_id    = lock_id_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = REQ_ID_NBITS'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (req_valid[cand]) begin
                    win_found = 1'b1;
                    win_id    = cand;
                end
            end
        end
    end

    // One-hot form of the winner; a locked requester keeps its grant even while idle.
    always_comb begin
        win_onehot = '0;
        if (win_found) begin
            win_onehot[win_id] = 1'b1;
        end
    end

    // A slot is free when below depth, or when this cycle's ack frees the head slot.
    assign can_push = (outstanding < TAG_CNT_NBITS'(TAG_DEPTH)) | edit_mem_ack;
    assign req_gnt  = rst ? '0 : (win_onehot & {NUM_REQ{can_push}});
    assign accept   = |(req_valid & req_gnt);
    assign pop      = edit_mem_ack & (outstanding != '0);
    assign tag_head = tag_mem[rd_ptr_q];
    assign rr_next  = (win_id == REQ_ID_NBITS'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    // Arbiter next state: lock on a non-eop beat, release on the eop beat.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d = rr_next;
                    if (!req_eop[win_id]) begin
                        state_d   = LOCKED;
                        lock_id_d = win_id;
                    end
                end
            end
            LOCKED: begin
                if (accept && req_eop[lock_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Issue stage: register the accepted beat towards edit_mem; fields hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_mem_req     <= 1'b0;
            edit_mem_raddr   <= '0;
            edit_mem_port_id <= '0;
            edit_mem_eop     <= 1'b0;
        end else begin
            edit_mem_req <= accept;
            if (accept) begin
                edit_mem_raddr   <= req_raddr[win_id*ADDR_NBITS +: ADDR_NBITS];
                edit_mem_port_id <= req_port_id[win_id*ID_NBITS +: ID_NBITS];
                edit_mem_eop     <= req_eop[win_id];
            end
        end
    end

    // Tag storage: requester index of each issued read, in issue order.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr_q] <= win_id;
        end
    end

    // Tag FIFO pointers and outstanding count; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outstanding <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response stage: steer acked data to the head requester; flag acks with nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_unexp_ack <= 1'b0;
        end else begin
            rsp_valid <= pop ? (NUM_REQ'(1) << tag_head) : '0;
            if (pop) begin
                rsp_data <= edit_mem_rdata;
            end
            if (edit_mem_ack && (outstanding == '0)) begin
                err_unexp_ack <= 1'b1;
            end
        end
    end

endmodule
